// File: rtl/osc_bram_block_dp_if.sv
// osc_bram_block_dp_if: LMB-side BRAM bus for both ports of the block RAM.
// The controller drives enables/address/write data; the RAM returns read data.
interface osc_bram_block_dp_if #(
   parameter int C_PORT_DWIDTH = 32,
   parameter int C_PORT_AWIDTH = 32,
   parameter int C_NUM_WE      = C_PORT_DWIDTH / 8
);
   logic                       BRAM_EN_A;
   logic                       BRAM_EN_B;
   logic [0:C_NUM_WE-1]        BRAM_WEN_A;
   logic [0:C_NUM_WE-1]        BRAM_WEN_B;
   logic [0:C_PORT_AWIDTH-1]   BRAM_Addr_A;
   logic [0:C_PORT_AWIDTH-1]   BRAM_Addr_B;
   logic [0:C_PORT_DWIDTH-1]   BRAM_Dout_A;
   logic [0:C_PORT_DWIDTH-1]   BRAM_Dout_B;
   logic [0:C_PORT_DWIDTH-1]   BRAM_Din_A;
   logic [0:C_PORT_DWIDTH-1]   BRAM_Din_B;
   logic                       Collision;
   logic [0:15]                Collision_Count;

   modport master (
      output BRAM_EN_A, BRAM_EN_B,
      output BRAM_WEN_A, BRAM_WEN_B,
      output BRAM_Addr_A, BRAM_Addr_B,
      output BRAM_Dout_A, BRAM_Dout_B,
      input  BRAM_Din_A, BRAM_Din_B,
      input  Collision, Collision_Count
   );

   modport slave (
      input  BRAM_EN_A, BRAM_EN_B,
      input  BRAM_WEN_A, BRAM_WEN_B,
      input  BRAM_Addr_A, BRAM_Addr_B,
      input  BRAM_Dout_A, BRAM_Dout_B,
      output BRAM_Din_A, BRAM_Din_B,
      output Collision, Collision_Count
   );
endinterface

// File: rtl/osc_bram_block_dp.sv
// osc_bram_block_dp: parametrised true-dual-port LMB block RAM with
// optional output register, read-during-write mode and collision counter.
module osc_bram_block_dp #(
   parameter int C_MEMSIZE     = 'h10000,
   parameter int C_PORT_DWIDTH = 32,
   parameter int C_PORT_AWIDTH = 32,
   parameter int C_NUM_WE      = C_PORT_DWIDTH / 8,
   parameter int C_OUT_REG     = 0,
   parameter     C_RDW_MODE    = "WRITE_FIRST",
   parameter     C_FAMILY      = "spartan6"
) (
   input logic                BRAM_Clk,
   input logic                BRAM_Rst,
   osc_bram_block_dp_if.slave bus
);

   localparam int  MW    = $clog2(C_MEMSIZE);
   localparam int  BW    = $clog2(C_NUM_WE);
   localparam int  IW    = MW - BW;
   localparam int  DEPTH = C_MEMSIZE / C_NUM_WE;
   localparam int  LW    = C_PORT_DWIDTH / C_NUM_WE;
   localparam int  DW    = C_PORT_DWIDTH;
   localparam bit  WF    = (C_RDW_MODE == "WRITE_FIRST");

   if (!(DW == 8 || DW == 16 || DW == 32 || DW == 64)) begin : g_bad_dw
      $error("osc_bram_block_dp: unsupported data width");
   end
   if (C_NUM_WE * 8 != DW) begin : g_bad_we
      $error("osc_bram_block_dp: write enables must cover bytes");
   end
   if ((C_MEMSIZE & (C_MEMSIZE - 1)) != 0 || C_MEMSIZE < 2 * C_NUM_WE)
   begin : g_bad_ms
      $error("osc_bram_block_dp: bad memory size");
   end
   if (!(WF || C_RDW_MODE == "READ_FIRST")) begin : g_bad_rdw
      $error("osc_bram_block_dp: bad read-during-write mode");
   end
   if (C_FAMILY == "") begin : g_bad_fam
      $error("osc_bram_block_dp: empty family");
   end

   logic [C_PORT_AWIDTH-1:0] addr_a;
   logic [C_PORT_AWIDTH-1:0] addr_b;
   logic [IW-1:0]            idx_a;
   logic [IW-1:0]            idx_b;
   logic                     en_a;
   logic                     en_b;
   logic [0:C_NUM_WE-1]      wa;
   logic [0:C_NUM_WE-1]      wb;
   logic [0:C_NUM_WE-1]      wb_m;
   logic [0:DW-1]            dout_a;
   logic [0:DW-1]            dout_b;
   logic [0:DW-1]            old_a;
   logic [0:DW-1]            old_b;
   logic [0:DW-1]            new_a;
   logic [0:DW-1]            new_b;
   logic [0:DW-1]            rd_a;
   logic [0:DW-1]            rd_b;
   logic                     same;
   logic                     coll;
   logic                     coll_q;
   logic [15:0]              cnt;
   logic                     unused_addr;

   assign addr_a = bus.BRAM_Addr_A;
   assign addr_b = bus.BRAM_Addr_B;
   assign idx_a  = addr_a[MW-1:BW];
   assign idx_b  = addr_b[MW-1:BW];
   assign unused_addr = ^{addr_a, addr_b};

   assign en_a   = bus.BRAM_EN_A;
   assign en_b   = bus.BRAM_EN_B;
   assign dout_a = bus.BRAM_Dout_A;
   assign dout_b = bus.BRAM_Dout_B;

   // Writes at an edge coincident with reset are dropped
   assign wa = (en_a && !BRAM_Rst) ? bus.BRAM_WEN_A : '0;
   assign wb = (en_b && !BRAM_Rst) ? bus.BRAM_WEN_B : '0;

   assign same = en_a && en_b && (idx_a == idx_b);
   assign coll = same && (|bus.BRAM_WEN_A || |bus.BRAM_WEN_B);

   // Port A owns any lane both ports write in the same word
   assign wb_m = same ? (wb & ~wa) : wb;

   for (genvar g = 0; g < C_NUM_WE; g++) begin : g_lane
      logic [0:LW-1] ram [DEPTH];

      always_ff @(posedge BRAM_Clk) begin
         if (wa[g])
            ram[idx_a] <= dout_a[g*LW +: LW];
         if (wb_m[g])
            ram[idx_b] <= dout_b[g*LW +: LW];
      end

      assign old_a[g*LW +: LW] = ram[idx_a];
      assign old_b[g*LW +: LW] = ram[idx_b];
   end

   // Word as stored after this edge, seen from each port
   always_comb begin
      new_a = old_a;
      new_b = old_b;
      for (int i = 0; i < C_NUM_WE; i++) begin
         if (wa[i])
            new_a[i*LW +: LW] = dout_a[i*LW +: LW];
         else if (same && wb[i])
            new_a[i*LW +: LW] = dout_b[i*LW +: LW];
         if (same && wa[i])
            new_b[i*LW +: LW] = dout_a[i*LW +: LW];
         else if (wb[i])
            new_b[i*LW +: LW] = dout_b[i*LW +: LW];
      end
   end

   always_ff @(posedge BRAM_Clk or posedge BRAM_Rst) begin
      if (BRAM_Rst) begin
         rd_a <= '0;
         rd_b <= '0;
      end else begin
         if (en_a)
            rd_a <= (WF && |wa) ? new_a : old_a;
         if (en_b)
            rd_b <= (WF && |wb) ? new_b : old_b;
      end
   end

   if (C_OUT_REG != 0) begin : g_oreg
      logic          ld_a;
      logic          ld_b;
      logic [0:DW-1] out_a;
      logic [0:DW-1] out_b;

      always_ff @(posedge BRAM_Clk or posedge BRAM_Rst) begin
         if (BRAM_Rst) begin
            ld_a  <= 1'b0;
            ld_b  <= 1'b0;
            out_a <= '0;
            out_b <= '0;
         end else begin
            ld_a <= en_a;
            ld_b <= en_b;
            if (ld_a)
               out_a <= rd_a;
            if (ld_b)
               out_b <= rd_b;
         end
      end

      assign bus.BRAM_Din_A = out_a;
      assign bus.BRAM_Din_B = out_b;
   end else begin : g_noreg
      assign bus.BRAM_Din_A = rd_a;
      assign bus.BRAM_Din_B = rd_b;
   end

   always_ff @(posedge BRAM_Clk or posedge BRAM_Rst) begin
      if (BRAM_Rst) begin
         coll_q <= 1'b0;
         cnt    <= '0;
      end else begin
         coll_q <= coll;
         if (coll && cnt != 16'hFFFF)
            cnt <= cnt + 16'd1;
      end
   end

   assign bus.Collision       = coll_q;
   assign bus.Collision_Count = cnt;

endmodule

// File: tb/tb_osc_bram_block_dp.sv
// tb_osc_bram_block_dp: scoreboard bench over five configurations of the
// dual-port BRAM (32b WF/RF, 32b pipelined, 64b and 8b sweeps).
module tb_osc_bram_block_dp;

   localparam int ND   = 5;
   localparam int S_DA = 0;
   localparam int S_DB = 1;
   localparam int S_CO = 2;
   localparam int S_CN = 3;

   typedef struct {
      int          due;
      int          k;
      int          s;
      logic [63:0] exp;
      string       nm;
   } sb_t;

   sb_t sb[$];

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   logic        en_a [ND];
   logic        en_b [ND];
   logic [7:0]  wen_a[ND];
   logic [7:0]  wen_b[ND];
   logic [31:0] ad_a [ND];
   logic [31:0] ad_b [ND];
   logic [63:0] wd_a [ND];
   logic [63:0] wd_b [ND];
   wire  [63:0] din_a[ND];
   wire  [63:0] din_b[ND];
   wire         co   [ND];
   wire  [15:0] cn   [ND];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar k = 0; k < ND; k++) begin : g_dut
      localparam int DW = (k == 3) ? 64 : (k == 4) ? 8 : 32;
      localparam int MS = (k == 3) ? 'h2000 : (k == 4) ? 'h800 : 'h10000;
      localparam int NW = DW / 8;

      osc_bram_block_dp_if #(
         .C_PORT_DWIDTH(DW),
         .C_PORT_AWIDTH(32),
         .C_NUM_WE(NW)
      ) bus ();

      assign bus.BRAM_EN_A   = en_a[k];
      assign bus.BRAM_EN_B   = en_b[k];
      assign bus.BRAM_WEN_A  = wen_a[k][NW-1:0];
      assign bus.BRAM_WEN_B  = wen_b[k][NW-1:0];
      assign bus.BRAM_Addr_A = ad_a[k];
      assign bus.BRAM_Addr_B = ad_b[k];
      assign bus.BRAM_Dout_A = wd_a[k][DW-1:0];
      assign bus.BRAM_Dout_B = wd_b[k][DW-1:0];
      assign din_a[k] = 64'(bus.BRAM_Din_A);
      assign din_b[k] = 64'(bus.BRAM_Din_B);
      assign co[k]    = bus.Collision;
      assign cn[k]    = bus.Collision_Count;

      osc_bram_block_dp #(
         .C_MEMSIZE(MS),
         .C_PORT_DWIDTH(DW),
         .C_PORT_AWIDTH(32),
         .C_NUM_WE(NW),
         .C_OUT_REG((k == 2) ? 1 : 0),
         .C_RDW_MODE((k == 1) ? "READ_FIRST" : "WRITE_FIRST"),
         .C_FAMILY("spartan6")
      ) u_dut (
         .BRAM_Clk(clk),
         .BRAM_Rst(rst),
         .bus(bus)
      );
   end

   function automatic logic [63:0] act(int k, int s);
      case (s)
         S_DA:    return din_a[k];
         S_DB:    return din_b[k];
         S_CO:    return {63'd0, co[k]};
         default: return {48'd0, cn[k]};
      endcase
   endfunction

   // Monitor: compare every entry that falls due this cycle
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            tests++;
            if (act(sb[i].k, sb[i].s) !== sb[i].exp) begin
               fails++;
               $display("FAIL %s dut%0d cyc %0d: got %h expected %h",
                        sb[i].nm, sb[i].k, cyc,
                        act(sb[i].k, sb[i].s), sb[i].exp);
            end
            sb.delete(i);
         end
      end
   end

   task automatic nxt();
      @(negedge clk);
      for (int k = 0; k < ND; k++) begin
         en_a[k]  = 1'b0;
         en_b[k]  = 1'b0;
         wen_a[k] = '0;
         wen_b[k] = '0;
      end
   endtask

   task automatic drv(int k, bit p, logic [31:0] ad, logic [7:0] we,
                      logic [63:0] d);
      if (!p) begin
         en_a[k] = 1'b1; wen_a[k] = we; ad_a[k] = ad; wd_a[k] = d;
      end else begin
         en_b[k] = 1'b1; wen_b[k] = we; ad_b[k] = ad; wd_b[k] = d;
      end
   endtask

   task automatic chk(int k, int s, int dly, logic [63:0] e, string nm);
      sb.push_back('{cyc + dly, k, s, e, nm});
   endtask

   task automatic rd(int k, bit p, logic [31:0] ad, logic [63:0] e,
                     string nm);
      drv(k, p, ad, 8'h00, 64'd0);
      chk(k, p ? S_DB : S_DA, (k == 2) ? 2 : 1, e, nm);
   endtask

   function automatic logic [63:0] pat8(int i);
      return {56'd0, 8'(i * 37 + (i >> 8) + 5)};
   endfunction

   function automatic logic [63:0] pat64(int i);
      return {32'(i * 32'h9E3779B1), ~32'(i)};
   endfunction

   initial begin
      rst = 1'b1;
      for (int k = 0; k < ND; k++) begin
         en_a[k] = 1'b0; en_b[k] = 1'b0;
         wen_a[k] = '0;  wen_b[k] = '0;
         ad_a[k] = '0;   ad_b[k] = '0;
         wd_a[k] = '0;   wd_b[k] = '0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < ND; k++) begin
         chk(k, S_DA, 1, 64'd0, "rst_din_a");
         chk(k, S_DB, 1, 64'd0, "rst_din_b");
         chk(k, S_CN, 1, 64'd0, "rst_cnt");
      end
      nxt(); rst = 1'b0;

      // basic write/read, alias, byte lanes
      nxt(); drv(0, 0, 'h100, 8'hF, 64'hDEADBEEF);
      chk(0, S_DA, 1, 64'hDEADBEEF, "wf_merge");
      nxt(); rd(0, 1, 'h100, 64'hDEADBEEF, "basic");
      nxt(); rd(0, 1, 'h10100, 64'hDEADBEEF, "alias");
      nxt(); drv(0, 0, 'h200, 8'hF, 64'h11223344);
      nxt(); drv(0, 0, 'h200, 8'b0101, 64'hAABBCCDD);
      chk(0, S_DA, 1, 64'h11BB33DD, "lane_merge");
      nxt(); rd(0, 1, 'h200, 64'h11BB33DD, "lanes");
      rd(0, 0, 'h203, 64'h11BB33DD, "offset");

      // same-port read-during-write, WF on dut0 and RF on dut1
      nxt(); drv(0, 0, 'h40, 8'hF, 64'h0); drv(1, 0, 'h40, 8'hF, 64'h0);
      nxt(); drv(0, 0, 'h40, 8'hF, 64'h55); drv(1, 0, 'h40, 8'hF, 64'h55);
      chk(0, S_DA, 1, 64'h55, "wf_rdw");
      chk(1, S_DA, 1, 64'h0, "rf_rdw");
      nxt(); rd(1, 0, 'h40, 64'h55, "rf_next");

      // cross-port collisions
      nxt(); drv(0, 0, 'h400, 8'hF, 64'h0000FFFF);
      drv(0, 1, 'h400, 8'hF, 64'hFFFF0000);
      chk(0, S_DA, 1, 64'h0000FFFF, "ww_din_a");
      chk(0, S_DB, 1, 64'h0000FFFF, "ww_din_b");
      chk(0, S_CO, 1, 64'd1, "coll_pulse");
      chk(0, S_CN, 1, 64'd1, "coll_cnt1");
      nxt(); chk(0, S_CO, 1, 64'd0, "coll_drop");
      rd(0, 1, 'h400, 64'h0000FFFF, "ww_store");
      nxt(); drv(0, 0, 'h500, 8'b1100, 64'h11223344);
      drv(0, 1, 'h500, 8'b0011, 64'h55667788);
      chk(0, S_DA, 1, 64'h11227788, "disj_a");
      chk(0, S_CN, 1, 64'd2, "coll_cnt2");
      nxt(); rd(0, 1, 'h500, 64'h11227788, "disj_store");
      nxt(); drv(1, 0, 'h40, 8'hF, 64'h99);
      rd(1, 1, 'h40, 64'h55, "rf_rd_vs_wr");
      chk(1, S_DA, 1, 64'h55, "rf_wr_old");
      chk(1, S_CO, 1, 64'd1, "coll_k1");
      drv(0, 0, 'h100, 8'hF, 64'h01020304);
      rd(0, 1, 'h100, 64'hDEADBEEF, "wf_rd_vs_wr");
      chk(0, S_DA, 1, 64'h01020304, "wf_wr_new");
      nxt(); rd(1, 1, 'h40, 64'h99, "rf_after");
      rd(0, 1, 'h100, 64'h01020304, "wf_after");
      chk(0, S_CN, 1, 64'd3, "coll_cnt3");

      // saturation: 70001 back-to-back colliding edges
      nxt(); drv(0, 0, 'h600, 8'hF, 64'h1); drv(0, 1, 'h600, 8'hF, 64'h2);
      for (int i = 0; i < 70000; i++) begin
         @(negedge clk);
         if (i == 10) chk(0, S_CO, 1, 64'd1, "coll_b2b");
      end
      nxt(); chk(0, S_CN, 1, 64'hFFFF, "coll_sat");
      chk(0, S_CO, 1, 64'd0, "coll_end");

      // output-register pipeline on dut2
      nxt(); drv(2, 0, 'h10, 8'hF, 64'hA5A5A5A5);
      chk(2, S_DA, 2, 64'hA5A5A5A5, "pipe_wf");
      nxt(); drv(2, 0, 'h14, 8'hF, 64'h5A5A5A5A);
      nxt(); rd(2, 1, 'h10, 64'hA5A5A5A5, "pipe_rd0");
      chk(2, S_DB, 1, 64'd0, "pipe_lat");
      nxt(); rd(2, 1, 'h14, 64'h5A5A5A5A, "pipe_rd1");
      nxt(); nxt(); chk(2, S_DB, 1, 64'h5A5A5A5A, "pipe_hold");

      // asynchronous reset between edges, in-flight read and write dropped
      nxt(); drv(2, 1, 'h10, 8'h00, 64'd0);
      @(posedge clk); #2; rst = 1'b1;
      chk(2, S_DB, 0, 64'd0, "rst_async_b");
      chk(0, S_DA, 0, 64'd0, "rst_async_a");
      chk(0, S_CN, 0, 64'd0, "rst_cnt_clr");
      en_b[2] = 1'b0;
      drv(2, 0, 'h10, 8'hF, 64'hFFFFFFFF);
      @(posedge clk); #2;
      nxt(); rst = 1'b0;
      chk(2, S_DB, 1, 64'd0, "rd_lost");
      nxt(); rd(2, 1, 'h10, 64'hA5A5A5A5, "wr_suppr");

      // width/depth sweep: 64b x 1024 on dut3, 8b x 2048 on dut4
      for (int i = 0; i < 2048; i++) begin
         nxt(); drv(4, 0, i, 8'h01, pat8(i));
         if (i < 1024) drv(3, 0, i * 8, 8'hFF, pat64(i));
      end
      for (int i = 0; i < 2048; i++) begin
         nxt(); rd(4, 1, i, pat8(i), "sweep8");
         if (i < 1024) rd(3, 1, i * 8, pat64(i), "sweep64");
      end

      repeat (4) nxt();
      foreach (sb[i]) begin
         tests++;
         fails++;
         $display("FAIL %s dut%0d: never checked, expected %h",
                  sb[i].nm, sb[i].k, sb[i].exp);
      end
      tests++;
      if (cn[0] !== 16'h0000) begin
         fails++;
         $display("FAIL final_cnt dut0: got %h expected 0000", cn[0]);
      end
      if (tests < 12) begin
         fails++;
         $display("FAIL too few checks: %0d", tests);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      if (fails == 0)
         $display("[TB] PASS");
      else
         $display("[TB] FAIL");
      $finish;
   end

endmodule

// File: doc/osc_bram_block_dp.md
# osc_bram_block_dp

Parametrised true-dual-port block RAM for the MicroBlaze local-memory subsystem. It is the successor to the fixed 64 KiB, 32-bit BRAM block. Both LMB ports share one clock, and the block adds:
- configurable data width and depth,
- an optional output pipeline register,
- a selectable same-port read-during-write mode,
- deterministic cross-port collision resolution with a saturating collision counter.

It sits between the instruction-side and data-side LMB BRAM interface controllers.

## Interface
Parameters:
- C_MEMSIZE, 'h10000: memory size in bytes; power of two, at least 2*C_NUM_WE.
- C_PORT_DWIDTH, 32: data width; one of 8, 16, 32, 64.
- C_PORT_AWIDTH, 32: byte-address width.
- C_NUM_WE, C_PORT_DWIDTH/8: byte write enables per port.
- C_OUT_REG, 0: 1 adds an output register, giving read latency 2.
- C_RDW_MODE, "WRITE_FIRST": same-port read-during-write result; "WRITE_FIRST" or "READ_FIRST".
- C_FAMILY, "spartan6": target family, passed to the inference attributes.

Ports (bit 0 is the MSB on all vectors):
- BRAM_Clk, in, 1: single clock for both ports.
- BRAM_Rst, in, 1: asynchronous, active-high reset.
- BRAM_EN_A / BRAM_EN_B, in, 1: port access enable.
- BRAM_WEN_A / BRAM_WEN_B, in, [0:C_NUM_WE-1]: byte write enables; WEN[i] writes data bits [8i:8i+7].
- BRAM_Addr_A / BRAM_Addr_B, in, [0:C_PORT_AWIDTH-1]: byte address.
- BRAM_Dout_A / BRAM_Dout_B, in, [0:C_PORT_DWIDTH-1]: write data from the controller.
- BRAM_Din_A / BRAM_Din_B, out, [0:C_PORT_DWIDTH-1]: read data to the controller.
- Collision, out, 1: one-cycle pulse, registered, marking a cross-port collision.
- Collision_Count, out, [0:15]: saturating count of collisions.

## Operation
- Word index: Addr[C_PORT_AWIDTH-log2(C_MEMSIZE) : C_PORT_AWIDTH-1-log2(C_NUM_WE)].
  - Upper address bits are ignored, so accesses alias modulo C_MEMSIZE.
  - Low byte-offset bits are ignored.
- Access when EN=1:
  - Every enabled cycle is a read.
  - Each byte with WEN[i]=1 is written at the clock edge.
  - EN=0: no read and no write; BRAM_Din holds its last value, and WEN is ignored.
- Same-port read-during-write:
  - WRITE_FIRST: Din returns the merged word, i.e. newly written bytes plus unwritten old bytes.
  - READ_FIRST: Din returns the pre-write word.
- Cross-port collision: both EN=1, equal word index, and at least one port has any WEN bit set. Resolution:
  - Write/write on the same byte lane: port A's byte is stored. Disjoint lanes both land.
  - Read on one port against a write on the other: the reading port gets the pre-write word.
  - The writing port still follows C_RDW_MODE for its own Din; under WRITE_FIRST its merged view reflects the stored result with A winning.
  - Collision pulses high in the following cycle.
  - Collision_Count increments and saturates at 16'hFFFF.
- Reset effects:
  - Clears the Din registers (read and output stages), Collision and Collision_Count.
  - Memory contents are not initialised or cleared.
  - A write at the clock edge coincident with BRAM_Rst asserted is suppressed.
- The block exerts no backpressure and accepts one access per port per cycle.

## Timing
- Reset values: BRAM_Din_A = BRAM_Din_B = 0, Collision = 0, Collision_Count = 0.
- Read latency is 1 + C_OUT_REG cycles from the EN sample edge to valid Din.
- With C_OUT_REG=1:
  - The output stage advances only if the read stage loaded in the previous cycle, so EN gaps hold Din stable.
  - A read issued in the last cycle before reset never appears.
- Write visibility:
  - A write at edge N is visible to a read, on either port, sampled at edge N+1.
  - Under WRITE_FIRST it is also visible to a same-port read sampled at edge N.
- Collision timing: asserted one cycle after the colliding edge, for exactly one cycle per colliding edge. Back-to-back collisions keep it high.
- Reset mid-operation: outputs go to 0 asynchronously; in-flight reads are discarded. The first access after deassertion behaves normally.

## Test plan
- Basic write/read: 32-bit, C_OUT_REG=0. Port A writes 32'hDEADBEEF at byte address 'h0100 with WEN=1111. Port B then reads 'h0100 and must return DEADBEEF 1 cycle later. Reading 'h10100 (alias) returns the same value.
- Byte lanes: with word 'h11223344 stored, write 32'hAABBCCDD with WEN=0101. A readback must give 32'h11BB33DD.
- Read-during-write mode: same-port write of 'h55 over 'h00.
  - WRITE_FIRST: Din shows the new word that cycle.
  - READ_FIRST: Din shows the old word that cycle and the new word on the next read.
- Write/write collision: A writes 'h0000FFFF and B writes 'hFFFF0000, both with WEN=1111, same address, same edge.
  - Stored value is 'h0000FFFF.
  - Collision pulses once; Collision_Count = 1.
  - Run 70000 colliding cycles: the count saturates at FFFF.
- Pipeline and reset: C_OUT_REG=1 with reads every cycle.
  - Data appears 2 cycles after EN.
  - Assert BRAM_Rst asynchronously between edges: Din_A/B go to 0 immediately, and a same-edge write is suppressed (verified by readback).
- Width/depth sweep: C_PORT_DWIDTH=64 with C_MEMSIZE='h2000, then 8 with 'h800. Fill memory through port A, read through port B, and all words must match.
